prime_search: RTL and testbench
===============================

PRIME_SEARCH -- requirements
Module: prime_search

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning candidate/result width in bits (minimum 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port go  input  1  search request; only a 0->1 transition is acted on.
REQ-005 SHALL have port mode  input  1  0 = next prime after current res; 1 = smallest prime >= from.
REQ-006 SHALL have port from  input  WIDTH  start value; sampled only on the go rising-edge cycle when mode=1.
REQ-007 SHALL have port ready  output  1  high when idle (READY or ERROR state).
REQ-008 SHALL have port error  output  1  high in ERROR state (overflow or divider error).
REQ-009 SHALL have port res  output  WIDTH  last prime found.
REQ-010 SHALL have port count  output  WIDTH  number of primes found since reset; wraps modulo 2^WIDTH.

Function
REQ-011 SHALL use states READY, ERROR, CHECK, WAIT_DLY, WAIT_MOD; ready/error registered from next state.
REQ-012 SHALL detect a go rising edge via a registered go_prev; go held high SHALL start exactly one search.
REQ-013 SHALL, on a go rising edge in any state, discard any search in progress and enter CHECK with div=2, div_sq=4.
REQ-014 SHALL, for mode=0, set the first candidate to 2 if res=1, 3 if res=2, otherwise res+2.
REQ-015 SHALL, for mode=1, set the first candidate to 2 if from<=2, from if from is odd, otherwise from+1.
REQ-016 SHALL compute candidates in WIDTH+1 bits; a candidate > 2^WIDTH-1 SHALL go to ERROR with res and count unchanged.
REQ-017 CHECK: if div_sq > p, p is prime: res<=p, count<=count+1, go to READY; else pulse mod go for one cycle and go to WAIT_DLY.
REQ-018 WAIT_DLY SHALL last exactly one cycle, then WAIT_MOD.
REQ-019 WAIT_MOD: divider error -> ERROR; divider ready with remainder 0 -> candidate p+2 (overflow per REQ-016), div=2, div_sq=4, CHECK; remainder nonzero -> next divisor, CHECK; otherwise stay.
REQ-020 SHALL step divisors 2,3,5,7,9,... (2->3, thereafter +2); div_sq updated incrementally (4 for 2->3 step: set to 9; else div_sq+4*div+4).
REQ-021 SHALL hold div_sq in WIDTH+2 bits so the REQ-017 comparison never wraps.
REQ-022 SHALL hold res, count and error stable while busy; ready SHALL be 0 from the cycle after a go edge until the search ends.
REQ-023 SHALL, from ERROR, remain there until a go rising edge or reset; a new go edge SHALL clear error on the next cycle.

Reset
REQ-024 SHALL, while rst is high and without a clock edge, force state=READY, ready=1, error=0, res=1, count=0, mod go=0, go_prev=0.
REQ-025 SHALL abandon any search immediately on rst assertion; first go edge after release starts fresh.

Structure
REQ-026 SHALL place state encodings (3-bit) and the initial res value in a shared package prime_pkg.
REQ-027 SHALL instantiate one sub-module divmod (ports clk, go, rst, a=p, b=div, ready, error, mod), WIDTH passed through, reset by the same rst.
REQ-028 SHALL keep combinational next-state logic separate from the registered state update.

Verification
REQ-029 Reset, mode=0, six go pulses -> res 2,3,5,7,11,13; count=6; error=0 throughout.
REQ-030 mode=1: from=24 -> res=29; from=0 -> res=2; from=97 -> res=97; count increments by 1 each.
REQ-031 WIDTH=8, mode=1, from=252 -> error=1, ready=1, res and count unchanged; next go with from=250 -> res=251, error=0.
REQ-032 mode=1 from=1000 go edge, 3 cycles later new go edge with from=14 -> res=17, count+1 only once.
REQ-033 rst asserted mid-search between clock edges -> ready=1, res=1, count=0 before the next clk edge.
REQ-034 go held high 200 cycles after one edge -> exactly one search, count+1 only.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared definitions for the prime search engine: FSM state encodings and reset value of res.
package prime_pkg;

    typedef enum logic [2:0] {
        StReady   = 3'd0,
        StError   = 3'd1,
        StCheck   = 3'd2,
        StWaitDly = 3'd3,
        StWaitMod = 3'd4
    } state_e;

    // res starts at 1 so that a mode=0 request after reset yields 2.
    localparam int unsigned ResInit = 1;

endpackage

// File: rtl/divmod.sv
// Sequential restoring divider: computes a mod b, one quotient bit per cycle.
// A go pulse (re)starts the operation; b == 0 reports error instead.
module divmod #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] mod
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_shift;

    // Next-state: latch operands on go, otherwise shift/subtract while busy.
    always_comb begin
        busy_d    = busy_q;
        ready_d   = ready_q;
        error_d   = error_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        rem_shift = {rem_q, a_q[WIDTH-1]};
        if (go) begin
            if (b == '0) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                error_d = 1'b1;
            end else begin
                a_d     = a;
                b_d     = b;
                rem_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                error_d = 1'b0;
            end
        end else if (busy_q) begin
            // The true difference is below b, so the low WIDTH bits are exact.
            if (rem_shift >= {1'b0, b_q}) begin
                rem_d = rem_shift[WIDTH-1:0] - b_q;
            end else begin
                rem_d = rem_shift[WIDTH-1:0];
            end
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            error_q <= error_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = ready_q;
    assign error = error_q;
    assign mod   = rem_q;

endmodule

// File: rtl/prime_search.sv
// Prime search engine: finds the next prime by trial division with odd divisors,
// using a sequential divider. Candidates that exceed WIDTH bits end in ERROR.
module prime_search
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             mode,
    input  logic [WIDTH-1:0] from,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] count
);

    state_e           state_q, state_d;
    logic             go_prev_q;
    logic             ready_q, error_q;
    logic             mod_go_q, mod_go_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH+1:0] div_sq_q, div_sq_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic             go_edge;
    logic [WIDTH:0]   first_cand, next_cand;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH+1:0] div_sq_next;
    logic             mod_ready, mod_error;
    logic [WIDTH-1:0] mod_rem;

    assign go_edge = go & ~go_prev_q;

    // Candidate and divisor arithmetic; one extra bit on candidates exposes overflow.
    always_comb begin
        if (!mode) begin
            if (res_q == WIDTH'(1)) begin
                first_cand = (WIDTH+1)'(2);
            end else if (res_q == WIDTH'(2)) begin
                first_cand = (WIDTH+1)'(3);
            end else begin
                first_cand = {1'b0, res_q} + (WIDTH+1)'(2);
            end
        end else begin
            if (from <= WIDTH'(2)) begin
                first_cand = (WIDTH+1)'(2);
            end else if (from[0]) begin
                first_cand = {1'b0, from};
            end else begin
                first_cand = {1'b0, from} + (WIDTH+1)'(1);
            end
        end
        next_cand = p_q + (WIDTH+1)'(2);
        if (div_q == WIDTH'(2)) begin
            div_next    = WIDTH'(3);
            div_sq_next = (WIDTH+2)'(9);
        end else begin
            div_next    = div_q + WIDTH'(2);
            div_sq_next = div_sq_q + {div_q, 2'b00} + (WIDTH+2)'(4);
        end
    end

    // Next-state logic; a go edge overrides whatever the FSM is doing.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        div_d    = div_q;
        div_sq_d = div_sq_q;
        res_d    = res_q;
        count_d  = count_q;
        mod_go_d = 1'b0;
        if (go_edge) begin
            if (first_cand[WIDTH]) begin
                state_d = StError;
            end else begin
                state_d  = StCheck;
                p_d      = first_cand;
                div_d    = WIDTH'(2);
                div_sq_d = (WIDTH+2)'(4);
            end
        end else begin
            unique case (state_q)
                StCheck: begin
                    if (div_sq_q > {1'b0, p_q}) begin
                        res_d   = p_q[WIDTH-1:0];
                        count_d = count_q + 1'b1;
                        state_d = StReady;
                    end else begin
                        mod_go_d = 1'b1;
                        state_d  = StWaitDly;
                    end
                end
                // Gives the divider a cycle to drop ready before it is polled.
                StWaitDly: state_d = StWaitMod;
                StWaitMod: begin
                    if (mod_error) begin
                        state_d = StError;
                    end else if (mod_ready) begin
                        if (mod_rem == '0) begin
                            if (next_cand[WIDTH]) begin
                                state_d = StError;
                            end else begin
                                p_d      = next_cand;
                                div_d    = WIDTH'(2);
                                div_sq_d = (WIDTH+2)'(4);
                                state_d  = StCheck;
                            end
                        end else begin
                            div_d    = div_next;
                            div_sq_d = div_sq_next;
                            state_d  = StCheck;
                        end
                    end
                end
                StReady, StError: ;
                default: state_d = StReady;
            endcase
        end
    end

    // Registered state; ready/error are derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReady;
            go_prev_q <= 1'b0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
            mod_go_q  <= 1'b0;
            p_q       <= '0;
            div_q     <= WIDTH'(2);
            div_sq_q  <= (WIDTH+2)'(4);
            res_q     <= WIDTH'(ResInit);
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            go_prev_q <= go;
            ready_q   <= (state_d == StReady) || (state_d == StError);
            error_q   <= (state_d == StError);
            mod_go_q  <= mod_go_d;
            p_q       <= p_d;
            div_q     <= div_d;
            div_sq_q  <= div_sq_d;
            res_q     <= res_d;
            count_q   <= count_d;
        end
    end

    divmod #(
        .WIDTH(WIDTH)
    ) u_divmod (
        .clk   (clk),
        .rst   (rst),
        .go    (mod_go_q),
        .a     (p_q[WIDTH-1:0]),
        .b     (div_q),
        .ready (mod_ready),
        .error (mod_error),
        .mod   (mod_rem)
    );

    assign ready = ready_q;
    assign error = error_q;
    assign res   = res_q;
    assign count = count_q;

endmodule

// File: tb/tb_prime_search.sv
// Self-checking bench for prime_search: a 16-bit and an 8-bit instance checked
// against a plain trial-division reference model.
module tb_prime_search;

    localparam int Budget = 15000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go16 = 1'b0;
    logic        go8 = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] from16 = '0;
    logic        ready16, error16, ready8, error8;
    logic [15:0] res16, count16;
    logic [7:0]  res8, count8;
    logic        sel = 1'b0;

    logic        s_ready, s_error;
    logic [15:0] s_res, s_count;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned exp_res [2];
    int unsigned exp_cnt [2];
    bit          exp_err [2];

    typedef struct {
        bit          m;
        int unsigned f;
        int unsigned exp_res;
    } vec_t;

    vec_t tbl [9];

    prime_search #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .go    (go16),
        .mode  (mode),
        .from  (from16),
        .ready (ready16),
        .error (error16),
        .res   (res16),
        .count (count16)
    );

    prime_search #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .go    (go8),
        .mode  (mode),
        .from  (from16[7:0]),
        .ready (ready8),
        .error (error8),
        .res   (res8),
        .count (count8)
    );

    always #5 clk = ~clk;

    assign s_ready = sel ? ready8 : ready16;
    assign s_error = sel ? error8 : error16;
    assign s_res   = sel ? {8'b0, res8} : res16;
    assign s_count = sel ? {8'b0, count8} : count16;

    initial begin
        #800000;
        $display("FAIL watchdog: run still active at 800us, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: smallest prime > res (mode 0) or >= from (mode 1) that fits.
    task automatic model_search(input int w, input bit m, input int unsigned f);
        int unsigned max_v = (w != 0) ? 255 : 65535;
        int unsigned target = m ? f : exp_res[w] + 1;
        bit          found = 1'b0;
        int unsigned val = 0;
        for (int unsigned n = target; n <= max_v && !found; n++) begin
            if (is_prime(n)) begin
                found = 1'b1;
                val   = n;
            end
        end
        if (found) begin
            exp_res[w] = val;
            exp_cnt[w] = (exp_cnt[w] + 1) % (max_v + 1);
            exp_err[w] = 1'b0;
        end else begin
            exp_err[w] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_res[i] = 1;
            exp_cnt[i] = 0;
            exp_err[i] = 1'b0;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!s_ready && n < Budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready at end"}, s_ready, 1);
    endtask

    task automatic compare_model(input int w, input string tag);
        check({tag, " res"}, s_res, exp_res[w]);
        check({tag, " count"}, s_count, exp_cnt[w]);
        check({tag, " error"}, s_error, exp_err[w]);
    endtask

    task automatic do_search(input bit w, input bit m, input int unsigned f, input string tag);
        sel = w;
        @(negedge clk);
        mode   = m;
        from16 = f[15:0];
        if (w) go8 = 1'b1;
        else go16 = 1'b1;
        @(negedge clk);
        check({tag, " busy after go"}, s_ready, 0);
        go8  = 1'b0;
        go16 = 1'b0;
        wait_ready(tag);
        model_search(w, m, f);
        compare_model(w, tag);
    endtask

    initial begin
        tbl[0] = '{1'b0, 0, 2};
        tbl[1] = '{1'b0, 0, 3};
        tbl[2] = '{1'b0, 0, 5};
        tbl[3] = '{1'b0, 0, 7};
        tbl[4] = '{1'b0, 0, 11};
        tbl[5] = '{1'b0, 0, 13};
        tbl[6] = '{1'b1, 24, 29};
        tbl[7] = '{1'b1, 0, 2};
        tbl[8] = '{1'b1, 97, 97};

        // Asynchronous reset visible before any clock edge.
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset ready16", ready16, 1);
        check("reset error16", error16, 0);
        check("reset res16", res16, 1);
        check("reset count16", count16, 0);
        check("reset ready8", ready8, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: six successive primes, then from-based searches.
        for (int i = 0; i < 9; i++) begin
            do_search(1'b0, tbl[i].m, tbl[i].f, $sformatf("tbl[%0d]", i));
            check($sformatf("tbl[%0d] res const", i), res16, tbl[i].exp_res);
            check($sformatf("tbl[%0d] count const", i), count16, i + 1);
        end

        // go held high: exactly one search.
        sel = 1'b0;
        @(negedge clk);
        mode = 1'b0;
        go16 = 1'b1;
        repeat (200) @(negedge clk);
        go16 = 1'b0;
        model_search(0, 1'b0, 0);
        check("held go ready", ready16, 1);
        compare_model(0, "held go");
        repeat (3) @(negedge clk);
        check("held go count later", count16, exp_cnt[0]);

        // A second go edge restarts an in-flight search.
        @(negedge clk);
        mode   = 1'b1;
        from16 = 16'd1000;
        go16   = 1'b1;
        @(negedge clk);
        go16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        from16 = 16'd14;
        go16   = 1'b1;
        @(negedge clk);
        go16 = 1'b0;
        wait_ready("restart");
        model_search(0, 1'b1, 14);
        compare_model(0, "restart");
        check("restart res const", res16, 17);

        // 8-bit overflow into ERROR, then recovery.
        do_search(1'b1, 1'b1, 100, "w8 from100");
        do_search(1'b1, 1'b1, 252, "w8 from252");
        check("w8 overflow error const", error8, 1);
        check("w8 overflow res kept", res8, 101);
        do_search(1'b1, 1'b1, 250, "w8 from250");
        check("w8 recover res const", res8, 251);
        check("w8 recover error const", error8, 0);

        // Randomized searches on both widths.
        for (int i = 0; i < 14; i++) begin
            bit          w = 1'($urandom_range(0, 1));
            bit          m = 1'($urandom_range(0, 1));
            int unsigned f = w ? $urandom_range(0, 255) : $urandom_range(0, 5000);
            do_search(w, m, f, $sformatf("rand[%0d] w8=%0d m=%0d f=%0d", i, w, m, f));
        end

        // Reset mid-search, checked between clock edges.
        sel = 1'b0;
        @(negedge clk);
        mode   = 1'b1;
        from16 = 16'd1000;
        go16   = 1'b1;
        @(negedge clk);
        go16 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid-search busy", ready16, 0);
        #2 rst = 1'b1;
        #1;
        check("mid rst ready16", ready16, 1);
        check("mid rst res16", res16, 1);
        check("mid rst count16", count16, 0);
        check("mid rst error16", error16, 0);
        check("mid rst count8", count8, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_search(1'b0, 1'b0, 0, "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
